// File: rtl/alu_nibble_seq.sv
// alu_nibble_seq: multi-cycle WIDTH-bit ALU that time-multiplexes one external
// 4-bit combinational alu_slice. Operands are walked LSB nibble first; carry is
// rippled through the slice's prop/gen outputs, and per-nibble zero flags are
// folded into a word-level ZERO flag.
//
// Optional build macro: ALU_NIBBLE_SEQ_OVERFLOW_EN adds the signed-overflow
// output V. Without it, the port and its logic are absent.
//
// Opcode encoding shared with the slice (common::ALU_*):
//   0 NOP0, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT, 7 NOP1
module alu_nibble_seq #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             N_RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  input  logic             C_IN,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT,
  output logic             C_OUT,
  output logic             ZERO,
`ifdef ALU_NIBBLE_SEQ_OVERFLOW_EN
  output logic             V,
`endif
  output logic [3:0]       SLICE_A,
  output logic [3:0]       SLICE_B,
  output logic [2:0]       SLICE_OP,
  output logic             SLICE_C_IN,
  input  logic [7:0]       SLICE_OUT
);

  localparam int NIB   = WIDTH / 4;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_carry;
  logic             r_zacc;
  logic [WIDTH-1:0] r_res;

  logic w_run;
  logic w_done;
  logic w_addsub;
  logic w_unused;

  // Slice bit 7 carries no information for this sequencer.
  assign w_unused = SLICE_OUT[7];

  assign w_run    = (r_state == S_RUN);
  assign w_done   = (r_state == S_DONE);
  assign w_addsub = (r_op == OP_ADD) || (r_op == OP_SUB);

  // FSM, operand latch and nibble-by-nibble accumulation of the slice results.
  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_carry <= 1'b0;
      r_zacc  <= 1'b0;
      r_res   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (IN_VALID) begin
            r_a     <= A;
            r_b     <= B;
            r_op    <= OP;
            r_carry <= C_IN;
            r_zacc  <= 1'b1;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_res[4*r_idx +: 4] <= SLICE_OUT[3:0];
          r_carry             <= SLICE_OUT[5] | (SLICE_OUT[4] & r_carry);
          r_zacc              <= r_zacc & SLICE_OUT[6];
          if (r_idx == LAST_IDX) begin
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_DONE: begin
          if (OUT_READY) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Slice address: current nibble while running, all-zero otherwise.
  always_comb begin
    SLICE_A    = 4'h0;
    SLICE_B    = 4'h0;
    SLICE_OP   = 3'd0;
    SLICE_C_IN = 1'b0;
    if (w_run) begin
      SLICE_A    = r_a[4*r_idx +: 4];
      SLICE_B    = r_b[4*r_idx +: 4];
      SLICE_OP   = r_op;
      SLICE_C_IN = r_carry;
    end
  end

  // Handshake and result presentation; result fields read zero outside DONE.
  always_comb begin
    IN_READY  = (r_state == S_IDLE);
    OUT_VALID = w_done;
    OUT       = w_done ? r_res : '0;
    ZERO      = w_done & r_zacc;
    C_OUT     = w_done & w_addsub & r_carry;
  end

`ifdef ALU_NIBBLE_SEQ_OVERFLOW_EN
  logic w_am;
  logic w_bm;
  logic w_om;

  assign w_am = r_a[WIDTH-1];
  assign w_bm = r_b[WIDTH-1];
  assign w_om = r_res[WIDTH-1];

  // Signed overflow from the latched operand and result sign bits.
  always_comb begin
    V = 1'b0;
    if (w_done) begin
      if (r_op == OP_ADD) V = (w_am == w_bm) && (w_om != w_am);
      if (r_op == OP_SUB) V = (w_am != w_bm) && (w_om != w_am);
    end
  end
`endif

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Directed bench for alu_nibble_seq (WIDTH=32) with a behavioural 4-bit slice
// model wired to the SLICE_* port.
module tb_alu_nibble_seq;

  localparam logic [2:0] NOP0 = 3'd0;
  localparam logic [2:0] ADD  = 3'd1;
  localparam logic [2:0] SUB  = 3'd2;
  localparam logic [2:0] AND_ = 3'd3;
  localparam logic [2:0] OR_  = 3'd4;
  localparam logic [2:0] XOR_ = 3'd5;
  localparam logic [2:0] NOT_ = 3'd6;

  logic        CLK = 1'b0;
  logic        N_RST = 1'b0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [2:0]  OP = '0;
  logic        C_IN = 1'b0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b0;
  logic [31:0] OUT;
  logic        C_OUT;
  logic        ZERO;
`ifdef ALU_NIBBLE_SEQ_OVERFLOW_EN
  logic        V;
`endif
  logic [3:0]  SLICE_A;
  logic [3:0]  SLICE_B;
  logic [2:0]  SLICE_OP;
  logic        SLICE_C_IN;
  logic [7:0]  SLICE_OUT;

  int n_pass  = 0;
  int n_total = 0;

  always #5 CLK = ~CLK;

  alu_nibble_seq #(.WIDTH(32)) dut (
    .CLK(CLK), .N_RST(N_RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .OP(OP), .C_IN(C_IN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT(OUT),
    .C_OUT(C_OUT), .ZERO(ZERO),
`ifdef ALU_NIBBLE_SEQ_OVERFLOW_EN
    .V(V),
`endif
    .SLICE_A(SLICE_A), .SLICE_B(SLICE_B), .SLICE_OP(SLICE_OP),
    .SLICE_C_IN(SLICE_C_IN), .SLICE_OUT(SLICE_OUT)
  );

  // Behavioural alu_slice: [3:0] out, [4] prop, [5] gen, [6] zero.
  logic [3:0] s_bb;
  logic [4:0] s_sum5;
  logic [3:0] s_res;
  logic       s_p;
  logic       s_g;
  always_comb begin
    s_bb   = (SLICE_OP == SUB) ? ~SLICE_B : SLICE_B;
    s_sum5 = 5'(SLICE_A) + 5'(s_bb);
    s_res  = 4'h0;
    s_p    = 1'b0;
    s_g    = 1'b0;
    case (SLICE_OP)
      ADD, SUB: begin
        s_res = SLICE_A + s_bb + 4'(SLICE_C_IN);
        s_p   = (s_sum5 == 5'h0F);
        s_g   = s_sum5[4];
      end
      AND_:    s_res = SLICE_A & SLICE_B;
      OR_:     s_res = SLICE_A | SLICE_B;
      XOR_:    s_res = SLICE_A ^ SLICE_B;
      NOT_:    s_res = ~SLICE_A;
      default: s_res = 4'h0;
    endcase
    SLICE_OUT = {1'b0, (s_res == 4'h0), s_g, s_p, s_res};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Present a request and wait (bounded) for the accept edge; ends #1 after it.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic cin);
    int guard;
    guard = 0;
    while (!IN_READY && guard < 50) begin
      @(posedge CLK); #1; guard++;
    end
    check("ready_before_accept", 32'(IN_READY), 32'd1);
    OP = op; A = a; B = b; C_IN = cin; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
  endtask

  // Count cycles from the accept edge to OUT_VALID, bounded.
  task automatic wait_done(input string tag);
    int cyc;
    cyc = 0;
    while (!OUT_VALID && cyc < 20) begin
      @(posedge CLK); #1; cyc++;
    end
    check({tag, "_latency"}, 32'(cyc), 32'd8);
  endtask

  task automatic release_result();
    OUT_READY = 1'b1;
    @(posedge CLK); #1;
    OUT_READY = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_out_valid", 32'(OUT_VALID), 32'd0);
    check("rst_out",       OUT,            32'd0);
    check("rst_c_out",     32'(C_OUT),     32'd0);
    check("rst_zero",      32'(ZERO),      32'd0);
    check("rst_slice",     {19'd0, SLICE_A, SLICE_B, SLICE_OP, SLICE_C_IN, 1'b0}, 32'd0);
    @(negedge CLK); N_RST = 1'b1;
    @(posedge CLK); #1;
    check("rst_in_ready",  32'(IN_READY),  32'd1);

    // ADD with carry ripple across four nibbles
    start_op(ADD, 32'h0000FFFF, 32'h00000001, 1'b0);
    check("add1_in_ready_run", 32'(IN_READY), 32'd0);
    wait_done("add1");
    check("add1_out",  OUT,            32'h00010000);
    check("add1_cout", 32'(C_OUT),     32'd0);
    check("add1_zero", 32'(ZERO),      32'd0);
`ifdef ALU_NIBBLE_SEQ_OVERFLOW_EN
    check("add1_v",    32'(V),         32'd0);
`endif
    release_result();
    check("add1_idle", 32'(IN_READY),  32'd1);

    // ADD wrapping to zero with carry out
    start_op(ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    wait_done("add2");
    check("add2_out",  OUT,        32'h00000000);
    check("add2_cout", 32'(C_OUT), 32'd1);
    check("add2_zero", 32'(ZERO),  32'd1);
    release_result();

    // SUB with borrow and without
    start_op(SUB, 32'd5, 32'd7, 1'b1);
    wait_done("sub1");
    check("sub1_out",  OUT,        32'hFFFFFFFE);
    check("sub1_cout", 32'(C_OUT), 32'd0);
    release_result();
    start_op(SUB, 32'd7, 32'd5, 1'b1);
    wait_done("sub2");
    check("sub2_out",  OUT,        32'd2);
    check("sub2_cout", 32'(C_OUT), 32'd1);
    check("sub2_zero", 32'(ZERO),  32'd0);
    release_result();

    // AND; C_IN=1 must not leak into C_OUT for logic ops
    start_op(AND_, 32'hF0F01234, 32'h0FF0FFFF, 1'b1);
    wait_done("and");
    check("and_out",  OUT,        32'h00F01234);
    check("and_cout", 32'(C_OUT), 32'd0);
    check("and_zero", 32'(ZERO),  32'd0);
    release_result();

    // NOP0 with C_IN=1
    start_op(NOP0, 32'h12345678, 32'h9ABCDEF0, 1'b1);
    wait_done("nop0");
    check("nop0_out",  OUT,        32'd0);
    check("nop0_zero", 32'(ZERO),  32'd1);
    check("nop0_cout", 32'(C_OUT), 32'd0);
    release_result();

    // Back-pressure in DONE with an ignored IN_VALID pulse
    start_op(XOR_, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0);
    wait_done("hold");
    for (int i = 0; i < 5; i++) begin
      if (i == 2) IN_VALID = 1'b1;
      else        IN_VALID = 1'b0;
      @(posedge CLK); #1;
      check("hold_out",      OUT,             32'hAAAAAAAA);
      check("hold_valid",    32'(OUT_VALID),  32'd1);
      check("hold_in_ready", 32'(IN_READY),   32'd0);
    end
    IN_VALID = 1'b0;
    release_result();
    check("hold_idle_ready", 32'(IN_READY),  32'd1);
    check("hold_idle_valid", 32'(OUT_VALID), 32'd0);
    repeat (10) @(posedge CLK);
    #1;
    check("hold_pulse_ignored", {30'd0, OUT_VALID, IN_READY}, 32'd1);

    // Asynchronous reset in the middle of RUN (idx=3)
    start_op(ADD, 32'h11111111, 32'h22222222, 1'b1);
    repeat (3) @(posedge CLK);
    #1;
    check("mid_slice_a", 32'(SLICE_A), 32'd1);
    #2 N_RST = 1'b0;
    #1;
    check("mid_rst_valid", 32'(OUT_VALID), 32'd0);
    check("mid_rst_ready", 32'(IN_READY),  32'd1);
    check("mid_rst_out",   OUT,            32'd0);
    check("mid_rst_flags", {30'd0, C_OUT, ZERO}, 32'd0);
    check("mid_rst_slice", {19'd0, SLICE_A, SLICE_B, SLICE_OP, SLICE_C_IN, 1'b0}, 32'd0);
    @(negedge CLK); N_RST = 1'b1;
    @(posedge CLK); #1;
    start_op(ADD, 32'd1, 32'd1, 1'b0);
    wait_done("post_rst");
    check("post_rst_out",  OUT,        32'd2);
    check("post_rst_cout", 32'(C_OUT), 32'd0);
    release_result();

`ifdef ALU_NIBBLE_SEQ_OVERFLOW_EN
    start_op(ADD, 32'h7FFFFFFF, 32'd1, 1'b0);
    wait_done("ovf_add");
    check("ovf_add_out", OUT,    32'h80000000);
    check("ovf_add_v",   32'(V), 32'd1);
    release_result();
    start_op(SUB, 32'h80000000, 32'd1, 1'b1);
    wait_done("ovf_sub");
    check("ovf_sub_out", OUT,    32'h7FFFFFFF);
    check("ovf_sub_v",   32'(V), 32'd1);
    release_result();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
